// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic intersection controller: FSM states,
// operating modes and lamp codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'b00,
    MODE_BLINK     = 2'b01,
    MODE_HOLD      = 2'b10,
    MODE_BLINK_ALT = 2'b11
  } mode_e;

  localparam int unsigned LAMP_W = 3;

  // Lamp codes are {R,Y,G}.
  localparam logic [LAMP_W-1:0] RED    = 3'b100;
  localparam logic [LAMP_W-1:0] YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] GREEN  = 3'b001;
  localparam logic [LAMP_W-1:0] OFF    = 3'b000;

  function automatic logic is_blink(mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BLINK_ALT);
  endfunction

endpackage

// File: rtl/tl_blink_gen.sv
// Blink phase generator: toggles o_phase every HALF_CYC cycles; i_restart
// holds the counter and phase at zero.
module tl_blink_gen #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned HALF_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_phase
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == HALF_LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-direction intersection controller with pedestrian service, blink mode
// and all-red hold; lamps decode combinationally from registered state.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned GREEN_CYC      = 800000000,
  parameter int unsigned YELLOW_CYC     = 200000000,
  parameter int unsigned ALLRED_CYC     = 100000000,
  parameter int unsigned PED_CYC        = 500000000,
  parameter int unsigned MIN_GREEN_CYC  = 300000000,
  parameter int unsigned BLINK_HALF_CYC = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              ped_req,
  output logic [LAMP_W-1:0] ns_light,
  output logic [LAMP_W-1:0] ew_light,
  output logic              ped_walk,
  output logic              mode_light
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] MINGRN_LAST = CNT_W'(MIN_GREEN_CYC - 1);

  mode_e            r_mode;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped_pending;
  logic             r_ped_walk;

  mode_e            w_mode_in;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_walk_nxt;
  logic             w_green_done;
  logic [CNT_W-1:0] w_red_last;
  logic             w_blink_phase;

  assign w_mode_in    = mode_e'(mode);
  assign w_green_done = (r_cnt == GREEN_LAST) || (r_ped_pending && (r_cnt >= MINGRN_LAST));
  assign w_red_last   = r_ped_walk ? PED_LAST : ALLRED_LAST;

  tl_blink_gen #(
    .CNT_W    (CNT_W),
    .HALF_CYC (BLINK_HALF_CYC)
  ) u_blink (
    .clk       (clk),
    .rst       (rst),
    .i_restart (!is_blink(r_mode)),
    .o_phase   (w_blink_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode        <= MODE_NORMAL;
      r_state       <= ALL_RED_B;
      r_cnt         <= '0;
      r_ped_pending <= 1'b0;
      r_ped_walk    <= 1'b0;
    end else begin
      r_mode        <= w_mode_in;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ped_pending <= w_pend_nxt;
      r_ped_walk    <= w_walk_nxt;
    end
  end

  // Next state; re-entry into normal mode always restarts at the B clearance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_ped_pending;
    w_walk_nxt  = r_ped_walk;
    if ((w_mode_in == MODE_NORMAL) && (r_mode != MODE_NORMAL)) begin
      w_state_nxt = ALL_RED_B;
      w_cnt_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_walk_nxt  = 1'b0;
    end else if (r_mode != MODE_NORMAL) begin
      w_pend_nxt = 1'b0;
      w_walk_nxt = 1'b0;
      if (r_mode == MODE_HOLD) w_cnt_nxt = '0;
    end else begin
      if (ped_req && !r_ped_walk) w_pend_nxt = 1'b1;
      w_cnt_nxt = r_cnt + CNT_W'(1);
      case (r_state)
        NS_GREEN: if (w_green_done) begin
          w_state_nxt = NS_YELLOW;
          w_cnt_nxt   = '0;
        end
        EW_GREEN: if (w_green_done) begin
          w_state_nxt = EW_YELLOW;
          w_cnt_nxt   = '0;
        end
        // Entering clearance consumes any pending request as a walk phase.
        NS_YELLOW: if (r_cnt == YELLOW_LAST) begin
          w_state_nxt = ALL_RED_A;
          w_cnt_nxt   = '0;
          w_walk_nxt  = r_ped_pending;
          w_pend_nxt  = 1'b0;
        end
        EW_YELLOW: if (r_cnt == YELLOW_LAST) begin
          w_state_nxt = ALL_RED_B;
          w_cnt_nxt   = '0;
          w_walk_nxt  = r_ped_pending;
          w_pend_nxt  = 1'b0;
        end
        ALL_RED_A: if (r_cnt == w_red_last) begin
          w_state_nxt = EW_GREEN;
          w_cnt_nxt   = '0;
          w_walk_nxt  = 1'b0;
        end
        ALL_RED_B: if (r_cnt == w_red_last) begin
          w_state_nxt = NS_GREEN;
          w_cnt_nxt   = '0;
          w_walk_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ALL_RED_B;
          w_cnt_nxt   = '0;
          w_walk_nxt  = 1'b0;
        end
      endcase
    end
    if (r_state > ALL_RED_B) begin
      w_state_nxt = ALL_RED_B;
      w_cnt_nxt   = '0;
    end
  end

  // Lamp decode from registered mode, state and blink phase.
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    if (r_mode == MODE_NORMAL) begin
      case (r_state)
        NS_GREEN:  ns_light = GREEN;
        NS_YELLOW: ns_light = YELLOW;
        EW_GREEN:  ew_light = GREEN;
        EW_YELLOW: ew_light = YELLOW;
        default: begin
          ns_light = RED;
          ew_light = RED;
        end
      endcase
    end else if (r_mode != MODE_HOLD) begin
      ns_light = w_blink_phase ? OFF : YELLOW;
      ew_light = w_blink_phase ? OFF : YELLOW;
    end
  end

  assign ped_walk   = r_ped_walk && (r_mode == MODE_NORMAL);
  assign mode_light = (r_mode == MODE_NORMAL);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios with literal lamp
// sequences, then random mode/button traffic against a phase-table model.
module tb_traffic_intersection_ctrl;

  localparam int unsigned GREEN  = 8;
  localparam int unsigned YELLOW = 2;
  localparam int unsigned ALLRED = 1;
  localparam int unsigned PED    = 4;
  localparam int unsigned MING   = 3;
  localparam int unsigned BHALF  = 2;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LO = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       ped_walk, mode_light;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: phase index 0..5 around the ring NS_G,NS_Y,AR_A,EW_G,EW_Y,AR_B
  int m_mode, m_phase, m_elapsed, m_dur, m_age;
  bit m_pending, m_walk;

  traffic_intersection_ctrl #(
    .CNT_W          (32),
    .GREEN_CYC      (GREEN),
    .YELLOW_CYC     (YELLOW),
    .ALLRED_CYC     (ALLRED),
    .PED_CYC        (PED),
    .MIN_GREEN_CYC  (MING),
    .BLINK_HALF_CYC (BHALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .ped_req    (ped_req),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ped_walk   (ped_walk),
    .mode_light (mode_light)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ph_ns(int p);
    case (p)
      0: return LG;
      1: return LY;
      default: return LR;
    endcase
  endfunction

  function automatic logic [2:0] ph_ew(int p);
    case (p)
      3: return LG;
      4: return LY;
      default: return LR;
    endcase
  endfunction

  function automatic bit is_green(int p);
    return (p == 0) || (p == 3);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 5; m_elapsed = 0; m_dur = ALLRED;
    m_pending = 1'b0; m_walk = 1'b0; m_age = 0;
  endtask

  task automatic model_step(int mi, bit pr);
    bit np;
    if (m_mode == 1 || m_mode == 3) m_age++;
    else m_age = 0;
    if (mi == 0 && m_mode != 0) begin
      m_phase = 5; m_elapsed = 0; m_dur = ALLRED; m_pending = 1'b0; m_walk = 1'b0;
    end else if (m_mode == 2) begin
      m_elapsed = 0; m_pending = 1'b0; m_walk = 1'b0;
    end else if (m_mode != 0) begin
      m_pending = 1'b0; m_walk = 1'b0;
    end else begin
      np = m_pending || (pr && !m_walk);
      if ((m_elapsed + 1 >= m_dur) ||
          (is_green(m_phase) && m_pending && (m_elapsed + 1 >= int'(MING)))) begin
        m_phase = (m_phase + 1) % 6;
        m_elapsed = 0;
        if (m_phase == 2 || m_phase == 5) begin
          m_walk = m_pending;
          m_dur  = m_pending ? PED : ALLRED;
          np     = 1'b0;
        end else begin
          m_walk = 1'b0;
          m_dur  = is_green(m_phase) ? GREEN : YELLOW;
        end
      end else begin
        m_elapsed++;
      end
      m_pending = np;
    end
    m_mode = mi;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(int'(mode), ped_req);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [2:0] ens, eew;
    logic ew, eml;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_mode == 0) begin
          ens = ph_ns(m_phase); eew = ph_ew(m_phase); ew = m_walk; eml = 1'b1;
        end else if (m_mode == 2) begin
          ens = LR; eew = LR; ew = 1'b0; eml = 1'b0;
        end else begin
          ens = (((m_age / BHALF) % 2) != 0) ? LO : LY;
          eew = ens; ew = 1'b0; eml = 1'b0;
        end
        n_cmp++;
        if (ns_light !== ens || ew_light !== eew || ped_walk !== ew || mode_light !== eml) begin
          n_bad++;
          $display("FAIL model t=%0t got ns=%b ew=%b walk=%b ml=%b want ns=%b ew=%b walk=%b ml=%b",
                   $time, ns_light, ew_light, ped_walk, mode_light, ens, eew, ew, eml);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_now(string nm, logic [2:0] ens, logic [2:0] eew, logic ew, logic eml);
    n_cmp++;
    if (ns_light !== ens || ew_light !== eew || ped_walk !== ew || mode_light !== eml) begin
      n_bad++;
      $display("FAIL %s t=%0t got ns=%b ew=%b walk=%b ml=%b want ns=%b ew=%b walk=%b ml=%b",
               nm, $time, ns_light, ew_light, ped_walk, mode_light, ens, eew, ew, eml);
    end
  endtask

  task automatic expect_run(string nm, logic [2:0] ens, logic [2:0] eew, logic ew, logic eml, int n);
    for (int i = 0; i < n; i++) begin
      check_now($sformatf("%s[%0d]", nm, i), ens, eew, ew, eml);
      tick();
    end
  endtask

  task automatic run_boot(string tag);
    expect_run({tag, "_ar"},  LR, LR, 1'b0, 1'b1, 1);
    expect_run({tag, "_nsg"}, LG, LR, 1'b0, 1'b1, 8);
    expect_run({tag, "_nsy"}, LY, LR, 1'b0, 1'b1, 2);
    expect_run({tag, "_ara"}, LR, LR, 1'b0, 1'b1, 1);
    expect_run({tag, "_ewg"}, LR, LG, 1'b0, 1'b1, 8);
    expect_run({tag, "_ewy"}, LR, LY, 1'b0, 1'b1, 2);
    expect_run({tag, "_arb"}, LR, LR, 1'b0, 1'b1, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_now("reset", LR, LR, 1'b0, 1'b1);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_boot("boot");

    // Pedestrian pulse at NS green count 0
    ped_req = 1'b1;
    expect_run("ped_g0", LG, LR, 1'b0, 1'b1, 1);
    ped_req = 1'b0;
    expect_run("ped_g",   LG, LR, 1'b0, 1'b1, 2);
    expect_run("ped_y",   LY, LR, 1'b0, 1'b1, 2);
    expect_run("ped_ar",  LR, LR, 1'b1, 1'b1, 4);
    expect_run("ped_ewg", LR, LG, 1'b0, 1'b1, 3);

    // Blink entered during EW green; button presses ignored
    mode = 2'b01;
    expect_run("bl_pre", LR, LG, 1'b0, 1'b1, 1);
    expect_run("bl_on",  LY, LY, 1'b0, 1'b0, 2);
    expect_run("bl_off", LO, LO, 1'b0, 1'b0, 2);
    ped_req = 1'b1;
    expect_run("bl_on2", LY, LY, 1'b0, 1'b0, 2);
    ped_req = 1'b0;
    mode = 2'b00;
    expect_run("bl_last", LO, LO, 1'b0, 1'b0, 1);
    expect_run("rn_ar",   LR, LR, 1'b0, 1'b1, 1);
    expect_run("rn_nsg",  LG, LR, 1'b0, 1'b1, 8);
    expect_run("rn_nsy",  LY, LR, 1'b0, 1'b1, 2);

    // All-red hold with the button held
    mode = 2'b10;
    ped_req = 1'b1;
    expect_run("hold_pre", LR, LR, 1'b0, 1'b1, 1);
    expect_run("hold",     LR, LR, 1'b0, 1'b0, 20);
    mode = 2'b00;
    ped_req = 1'b0;
    expect_run("hold_last", LR, LR, 1'b0, 1'b0, 1);
    expect_run("hn_ar",     LR, LR, 1'b0, 1'b1, 1);
    expect_run("hn_nsg",    LG, LR, 1'b0, 1'b1, 8);
    expect_run("hn_nsy",    LY, LR, 1'b0, 1'b1, 1);

    // Asynchronous reset in the middle of NS yellow
    check_now("pre_rst", LY, LR, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_now("async_rst", LR, LR, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_boot("boot2");

    // Random mode changes and button traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        int r;
        r = int'($urandom_range(0, 5));
        mode = (r < 3) ? 2'b00 : 2'(r - 2);
      end
      ped_req = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter CNT_W, 32, width of the phase/blink counter.
REQ-002 Parameter GREEN_CYC, 800000000, green phase length in clk cycles (8 s @ 100 MHz).
REQ-003 Parameter YELLOW_CYC, 200000000, yellow phase length (2 s).
REQ-004 Parameter ALLRED_CYC, 100000000, all-red clearance length (1 s).
REQ-005 Parameter PED_CYC, 500000000, all-red length when a pedestrian request is served (5 s).
REQ-006 Parameter MIN_GREEN_CYC, 300000000, minimum green before a pedestrian request may cut it short (3 s).
REQ-007 Parameter BLINK_HALF_CYC, 50000000, blink half-period (0.5 s).
REQ-008 clk  input  1  clock.
REQ-009 rst  input  1  reset: asynchronous, active-high.
REQ-010 mode  input  2  00 normal, 01 blink, 10 all-red hold, 11 treated as blink.
REQ-011 ped_req  input  1  pedestrian button, level or pulse, sampled every cycle.
REQ-012 ns_light  output  3  north-south lamps {R,Y,G}: 100 red, 010 yellow, 001 green, 000 off.
REQ-013 ew_light  output  3  east-west lamps, same encoding.
REQ-014 ped_walk  output  1  walk signal, high while a pedestrian request is being served.
REQ-015 mode_light  output  1  high only while the registered mode is normal.

Function
REQ-016 mode SHALL be registered once (mode_r); all behaviour follows mode_r, giving 1-cycle input latency.
REQ-017 Normal-mode FSM states SHALL be NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN.
REQ-018 Phase counter SHALL be cleared on every state entry and SHALL increment each cycle; the state SHALL exit in the cycle count == duration-1, so every state lasts exactly its duration.
REQ-019 Lamps: in the green/yellow states the active direction SHALL show green/yellow and the other direction red; in the ALL_RED states both directions SHALL show red.
REQ-020 A ped_pending flag SHALL be set by ped_req=1 in normal mode while ped_walk=0; ped_req while ped_walk=1 SHALL be ignored.
REQ-021 In a green state with ped_pending=1 and count >= MIN_GREEN_CYC-1, the FSM SHALL exit to yellow that cycle; otherwise green SHALL run its full GREEN_CYC.
REQ-022 On entry to an ALL_RED state with ped_pending=1, that state SHALL last PED_CYC, ped_walk SHALL be 1 for its whole duration, and ped_pending SHALL clear at entry.
REQ-023 Blink mode: FSM state and phase counter SHALL freeze; the blink counter SHALL restart at 0 with phase 0; both directions SHALL show 010 in phase 0 and 000 in phase 1; phase SHALL toggle every BLINK_HALF_CYC cycles.
REQ-024 All-red hold: both directions SHALL show 100, ped_walk 0, and the phase counter SHALL be held at 0.
REQ-025 Outside normal mode, ped_pending SHALL be cleared and ped_req ignored.
REQ-026 On any transition of mode_r into normal, the FSM SHALL restart at ALL_RED_B with count 0 and ALLRED_CYC duration.
REQ-027 Counters SHALL be CNT_W bits wide, with no wrap in legal use; each duration parameter SHALL be >= 1 and < 2**CNT_W.
REQ-028 Unused state encodings SHALL recover to ALL_RED_B in the next cycle.

Reset
REQ-029 While rst=1: state ALL_RED_B, counters 0, ped_pending 0, blink phase 0, mode_r normal.
REQ-030 Outputs during reset: ns_light=ew_light=100, ped_walk=0, mode_light=1.
REQ-031 Reset asserted mid-phase SHALL force all-red immediately, without waiting for a clock edge.

Structure
REQ-032 A shared package traffic_pkg SHALL hold the state encoding, the mode encoding and the lamp codes (RED, YELLOW, GREEN, OFF).
REQ-033 A sub-module tl_blink_gen (counter and phase toggle, with a restart input) SHALL produce the blink phase.
REQ-034 Lamp decode SHALL be combinational from registered state only.

Verification (GREEN=8, YELLOW=2, ALLRED=1, PED=4, MIN_GREEN=3, BLINK_HALF=2)
REQ-035 Release reset with mode=00 -> both lamps 100 for 1 cycle, then NS 001 for 8 cycles, NS 010 for 2, all-red 1, then EW 001 for 8.
REQ-036 ped_req pulse at NS_GREEN count 0 -> green lasts 3 cycles, yellow 2, all-red 4 with ped_walk=1, then EW green for the full 8.
REQ-037 mode=01 during EW_GREEN -> one cycle later both lamps 010 for 2 cycles then 000 for 2, repeating; mode_light=0.
REQ-038 mode back to 00 from blink -> all-red 1 cycle, then NS 001; no pending pedestrian request survives.
REQ-039 mode=10 with ped_req held high -> both lamps 100 indefinitely, ped_walk=0; after mode=00, no early green cut occurs.
REQ-040 rst pulsed mid-NS_YELLOW -> lamps 100 asynchronously; after release the REQ-035 sequence repeats exactly.
